// File: rtl/poly_key_voice_alloc.sv
// rtl/poly_key_voice_alloc.sv - PS/2 scan-code decoder with polyphonic voice allocation.
// Make codes claim a voice slot (oldest stolen when full); break codes free it.
module poly_key_voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 7,
    parameter int RANK_W     = 3
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         scan_valid,
    input  logic [7:0]                   scan_code,
    input  logic [2:0]                   GLOBAL_octave,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES-1:0]        voice_trig,
    output logic [3:0]                   held_count
);

    localparam int                 IDX_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [RANK_W-1:0]  OLDEST  = RANK_W'(NUM_VOICES - 1);
    localparam logic [NOTE_W-1:0]  NO_NOTE = '1;

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

    // Result packing: {hit, octave offset (3-bit signed), semitone}
    function automatic logic [7:0] key_lookup(input logic [7:0] code);
        logic [7:0] res;
        case (code)
            8'h15: res = {1'b1, 3'b000, 4'd0};
            8'h1E: res = {1'b1, 3'b000, 4'd1};
            8'h1D: res = {1'b1, 3'b000, 4'd2};
            8'h26: res = {1'b1, 3'b000, 4'd3};
            8'h24: res = {1'b1, 3'b000, 4'd4};
            8'h2D: res = {1'b1, 3'b000, 4'd5};
            8'h2E: res = {1'b1, 3'b000, 4'd6};
            8'h2C: res = {1'b1, 3'b000, 4'd7};
            8'h36: res = {1'b1, 3'b000, 4'd8};
            8'h35: res = {1'b1, 3'b000, 4'd9};
            8'h3D: res = {1'b1, 3'b000, 4'd10};
            8'h3C: res = {1'b1, 3'b000, 4'd11};
            8'h43: res = {1'b1, 3'b001, 4'd0};
            8'h46: res = {1'b1, 3'b001, 4'd1};
            8'h44: res = {1'b1, 3'b001, 4'd2};
            8'h45: res = {1'b1, 3'b001, 4'd3};
            8'h4D: res = {1'b1, 3'b001, 4'd4};
            8'h54: res = {1'b1, 3'b001, 4'd5};
            8'h55: res = {1'b1, 3'b001, 4'd6};
            8'h5B: res = {1'b1, 3'b001, 4'd7};
            8'h1A: res = {1'b1, 3'b111, 4'd0};
            8'h1B: res = {1'b1, 3'b111, 4'd1};
            8'h22: res = {1'b1, 3'b111, 4'd2};
            8'h23: res = {1'b1, 3'b111, 4'd3};
            8'h21: res = {1'b1, 3'b111, 4'd4};
            8'h2A: res = {1'b1, 3'b111, 4'd5};
            8'h34: res = {1'b1, 3'b111, 4'd6};
            8'h32: res = {1'b1, 3'b111, 4'd7};
            8'h33: res = {1'b1, 3'b111, 4'd8};
            8'h31: res = {1'b1, 3'b111, 4'd9};
            8'h3B: res = {1'b1, 3'b111, 4'd10};
            8'h3A: res = {1'b1, 3'b111, 4'd11};
            8'h41: res = {1'b1, 3'b110, 4'd0};
            8'h4B: res = {1'b1, 3'b110, 4'd1};
            8'h49: res = {1'b1, 3'b110, 4'd2};
            8'h4C: res = {1'b1, 3'b110, 4'd3};
            8'h4A: res = {1'b1, 3'b110, 4'd4};
            default: res = 8'h00;
        endcase
        return res;
    endfunction

    state_t                 r_state;
    state_t                 w_state_n;
    logic [NOTE_W-1:0]      r_note [NUM_VOICES];
    logic [7:0]             r_key  [NUM_VOICES];
    logic [RANK_W-1:0]      r_rank [NUM_VOICES];
    logic [NUM_VOICES-1:0]  r_active;
    logic [NUM_VOICES-1:0]  r_trig;
    logic [3:0]             r_held;

    logic                   w_make;
    logic                   w_brk;
    logic [7:0]             w_map;
    logic signed [7:0]      w_oct_sum;
    logic signed [7:0]      w_note_s;
    logic                   w_note_ok;

    logic [NUM_VOICES-1:0]  w_key_hit;
    logic                   w_free_found;
    logic [IDX_W-1:0]       w_free_idx;
    logic [IDX_W-1:0]       w_old_idx;
    logic [IDX_W-1:0]       w_hit_idx;
    logic [IDX_W-1:0]       w_sel;

    logic [NOTE_W-1:0]      w_note_n [NUM_VOICES];
    logic [7:0]             w_key_n  [NUM_VOICES];
    logic [RANK_W-1:0]      w_rank_n [NUM_VOICES];
    logic [NUM_VOICES-1:0]  w_active_n;
    logic [NUM_VOICES-1:0]  w_trig_n;
    logic [3:0]             w_held_n;
    logic [RANK_W-1:0]      w_pivot;

    always_comb begin
        w_state_n = r_state;
        w_make    = 1'b0;
        w_brk     = 1'b0;
        if (scan_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (scan_code == 8'hE0)      w_state_n = S_EXT;
                    else if (scan_code == 8'hF0) w_state_n = S_BRK;
                    else                         w_make    = 1'b1;
                end
                S_BRK: begin
                    w_brk     = 1'b1;
                    w_state_n = S_IDLE;
                end
                S_EXT:     w_state_n = (scan_code == 8'hF0) ? S_EXT_BRK : S_IDLE;
                S_EXT_BRK: w_state_n = S_IDLE;
                default:   w_state_n = S_IDLE;
            endcase
        end
    end

    // Octave sum stays in 0..10, so the 8-bit signed note never overflows.
    always_comb begin
        w_map     = key_lookup(scan_code);
        w_oct_sum = $signed({5'b0, GLOBAL_octave}) + 8'sd2 + $signed({{5{w_map[6]}}, w_map[6:4]});
        w_note_s  = $signed({4'b0, w_map[3:0]}) + 8'sd12 * w_oct_sum;
        w_note_ok = w_map[7] && (w_note_s >= 8'sd0) && (w_note_s <= 8'sd107);
    end

    // Downward scan so the lowest matching index wins.
    always_comb begin
        w_key_hit    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_old_idx    = '0;
        w_hit_idx    = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            w_key_hit[i] = r_active[i] && (r_key[i] == scan_code);
            if (!r_active[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
            if (r_active[i] && (r_rank[i] == OLDEST)) w_old_idx = IDX_W'(i);
            if (w_key_hit[i]) w_hit_idx = IDX_W'(i);
        end
        w_sel = w_free_found ? w_free_idx : w_old_idx;
    end

    always_comb begin
        w_note_n   = r_note;
        w_key_n    = r_key;
        w_rank_n   = r_rank;
        w_active_n = r_active;
        w_trig_n   = '0;
        w_held_n   = r_held;
        w_pivot    = OLDEST;
        if (w_make && w_note_ok && !(|w_key_hit)) begin
            w_pivot = w_free_found ? OLDEST : r_rank[w_sel];
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == w_sel) begin
                    w_note_n[i]   = NOTE_W'(w_note_s);
                    w_key_n[i]    = scan_code;
                    w_rank_n[i]   = '0;
                    w_active_n[i] = 1'b1;
                    w_trig_n[i]   = 1'b1;
                end else if (r_active[i] && (r_rank[i] < w_pivot)) begin
                    w_rank_n[i] = r_rank[i] + RANK_W'(1);
                end
            end
            if (w_free_found) w_held_n = r_held + 4'd1;
        end else if (w_brk && (|w_key_hit)) begin
            w_pivot = r_rank[w_hit_idx];
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == w_hit_idx) begin
                    w_note_n[i]   = NO_NOTE;
                    w_rank_n[i]   = '0;
                    w_active_n[i] = 1'b0;
                end else if (r_active[i] && (r_rank[i] > w_pivot)) begin
                    w_rank_n[i] = r_rank[i] - RANK_W'(1);
                end
            end
            w_held_n = r_held - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_note[i] <= NO_NOTE;
                r_key[i]  <= 8'h00;
                r_rank[i] <= '0;
            end
            r_active <= '0;
            r_trig   <= '0;
            r_held   <= '0;
        end else begin
            r_state  <= w_state_n;
            r_note   <= w_note_n;
            r_key    <= w_key_n;
            r_rank   <= w_rank_n;
            r_active <= w_active_n;
            r_trig   <= w_trig_n;
            r_held   <= w_held_n;
        end
    end

    always_comb begin
        voice_note = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note[i*NOTE_W +: NOTE_W] = r_note[i];
        end
    end

    assign voice_active = r_active;
    assign voice_trig   = r_trig;
    assign held_count   = r_held;

endmodule

// File: tb/tb_poly_key_voice_alloc.sv
// tb/tb_poly_key_voice_alloc.sv - directed and randomized checks against an age-queue voice model.
module tb_poly_key_voice_alloc;
    localparam int NV = 4;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             scan_valid = 1'b0;
    logic [7:0]       scan_code = 8'h00;
    logic [2:0]       oct = 3'd3;
    logic [NV*7-1:0]  voice_note;
    logic [NV-1:0]    voice_active;
    logic [NV-1:0]    voice_trig;
    logic [3:0]       held_count;

    poly_key_voice_alloc #(.NUM_VOICES(NV), .NOTE_W(7), .RANK_W(3)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .scan_valid   (scan_valid),
        .scan_code    (scan_code),
        .GLOBAL_octave(oct),
        .voice_note   (voice_note),
        .voice_active (voice_active),
        .voice_trig   (voice_trig),
        .held_count   (held_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Key rows by octave offset; index within a row is the semitone.
    int row_p0[12] = '{'h15, 'h1E, 'h1D, 'h26, 'h24, 'h2D, 'h2E, 'h2C, 'h36, 'h35, 'h3D, 'h3C};
    int row_p1[8]  = '{'h43, 'h46, 'h44, 'h45, 'h4D, 'h54, 'h55, 'h5B};
    int row_m1[12] = '{'h1A, 'h1B, 'h22, 'h23, 'h21, 'h2A, 'h34, 'h32, 'h33, 'h31, 'h3B, 'h3A};
    int row_m2[5]  = '{'h41, 'h4B, 'h49, 'h4C, 'h4A};
    int pool[$];

    // Model: slot arrays plus a queue of active slots ordered newest-first.
    int          m_key  [NV];
    int          m_note [NV];
    bit          m_act  [NV];
    int          m_age[$];
    bit          m_ext;
    bit          m_brk;
    logic [NV-1:0] m_trig;

    function automatic int key_note(input int code, input int octv);
        int n;
        n = -1000;
        foreach (row_p0[s]) if (row_p0[s] == code) n = s + 12 * (octv + 2);
        foreach (row_p1[s]) if (row_p1[s] == code) n = s + 12 * (octv + 3);
        foreach (row_m1[s]) if (row_m1[s] == code) n = s + 12 * (octv + 1);
        foreach (row_m2[s]) if (row_m2[s] == code) n = s + 12 * octv;
        if (n < 0 || n > 107) return -1;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_key[i] = 0; m_note[i] = 127; m_act[i] = 0;
        end
        m_age.delete();
        m_ext = 0; m_brk = 0; m_trig = '0;
    endtask

    task automatic model_make(input int code);
        int n, slot;
        n = key_note(code, int'(oct));
        if (n < 0) return;
        for (int i = 0; i < NV; i++) if (m_act[i] && m_key[i] == code) return;
        slot = -1;
        for (int i = 0; i < NV; i++) if (!m_act[i] && slot < 0) slot = i;
        if (slot < 0) begin
            slot = m_age[$];
            m_age.pop_back();
        end
        m_age.push_front(slot);
        m_key[slot] = code; m_note[slot] = n; m_act[slot] = 1; m_trig[slot] = 1'b1;
    endtask

    task automatic model_break(input int code);
        for (int i = 0; i < NV; i++) begin
            if (m_act[i] && m_key[i] == code) begin
                m_act[i] = 0; m_note[i] = 127;
                for (int j = 0; j < m_age.size(); j++) if (m_age[j] == i) begin m_age.delete(j); break; end
                return;
            end
        end
    endtask

    task automatic model_byte(input int b);
        m_trig = '0;
        if (m_ext) begin
            if (!m_brk && b == 'hF0) m_brk = 1;
            else begin m_ext = 0; m_brk = 0; end
        end else if (m_brk) begin
            m_brk = 0;
            model_break(b);
        end else if (b == 'hE0) m_ext = 1;
        else if (b == 'hF0) m_brk = 1;
        else model_make(b);
    endtask

    task automatic compare_all(input string tag);
        logic [NV*7-1:0] en;
        logic [NV-1:0]   ea;
        for (int i = 0; i < NV; i++) begin
            en[i*7 +: 7] = m_note[i][6:0];
            ea[i] = m_act[i];
        end
        check_eq({tag, "_note"}, voice_note, en);
        check_eq({tag, "_active"}, voice_active, ea);
        check_eq({tag, "_trig"}, voice_trig, m_trig);
        check_eq({tag, "_held"}, held_count, m_age.size());
    endtask

    task automatic send(input string tag, input int b);
        @(negedge clk);
        scan_code  = b[7:0];
        scan_valid = 1'b1;
        model_byte(b);
        @(negedge clk);
        scan_valid = 1'b0;
        compare_all(tag);
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        m_trig = '0;
        compare_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int r, b;
        foreach (row_p0[i]) pool.push_back(row_p0[i]);
        foreach (row_p1[i]) pool.push_back(row_p1[i]);
        foreach (row_m1[i]) pool.push_back(row_m1[i]);
        foreach (row_m2[i]) pool.push_back(row_m2[i]);
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        resetn = 1'b1;

        oct = 3'd3;
        send("single_make", 'h15);
        check_eq("single_note60", voice_note[6:0], 60);
        check_eq("single_trig", voice_trig, 4'b0001);
        idle("single_trig_drop");
        send("single_f0", 'hF0);
        send("single_brk", 'h15);
        check_eq("single_rel_note", voice_note[6:0], 7'h7F);

        do_reset();
        foreach (row_p0[i]) if (i == 0 || i == 2 || i == 4 || i == 5) send("steal_fill", row_p0[i]);
        send("steal_new", 'h2C);
        check_eq("steal_note67", voice_note[6:0], 67);
        check_eq("steal_trig", voice_trig, 4'b0001);
        send("steal_f0", 'hF0);
        send("steal_stale_brk", 'h15);

        do_reset();
        repeat (4) send("typematic", 'h15);
        check_eq("typematic_held", held_count, 1);

        do_reset();
        oct = 3'd7;
        send("range_hi", 'h5B);
        check_eq("range_hi_held", held_count, 0);
        oct = 3'd0;
        send("range_lo", 'h4A);
        check_eq("range_lo_note4", voice_note[6:0], 4);

        do_reset();
        oct = 3'd3;
        send("ext_e0", 'hE0);
        send("ext_make", 'h75);
        send("ext_e0b", 'hE0);
        send("ext_f0", 'hF0);
        send("ext_brk", 'h75);
        send("midreset_f0", 'hF0);
        do_reset();
        compare_all("midreset_clear");
        send("midreset_make", 'h15);
        check_eq("midreset_note60", voice_note[6:0], 60);

        oct = 3'd5;
        idle("retune_hold");
        send("retune_new", 'h1D);
        check_eq("retune_note86", voice_note[13:7], 86);
        check_eq("retune_keep60", voice_note[6:0], 60);
        send("retune_fill_a", 'h24);
        send("retune_fill_b", 'h2D);
        send("retune_steal", 'h2C);
        check_eq("retune_steal_slot0", voice_trig, 4'b0001);

        do_reset();
        for (int it = 0; it < 3000; it++) begin
            r = $urandom_range(0, 999);
            if (r < 3) begin
                do_reset();
                compare_all("rnd_reset");
            end else if (r < 30) begin
                oct = 3'($urandom_range(0, 7));
            end else if (r < 250) begin
                idle("rnd_idle");
            end else begin
                r = $urandom_range(0, 99);
                if (r < 62)      b = pool[$urandom_range(0, pool.size() - 1)];
                else if (r < 82) b = 'hF0;
                else if (r < 88) b = 'hE0;
                else             b = $urandom_range(0, 255);
                send("rnd_byte", b);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
